// File: rtl/adder_bist_ctrl.sv
// Exhaustive BIST controller for the adder family: drives every operand pair, checks
// {carry,sum} after DUT_LAT stages, reports pass, error count and first failing pair.
module adder_bist_ctrl #(
    parameter int unsigned WIDTH   = 1,
    parameter int unsigned DUT_LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             carry_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic [WIDTH-1:0] fail_a,
    output logic [WIDTH-1:0] fail_b
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned NPAT  = 1 << PW;
    localparam int unsigned DEPTH = DUT_LAT + 1;
    localparam logic [PW-1:0] LAST_P = PW'(NPAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic             vld;
        logic             last;
        logic [WIDTH:0]   exp;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } exp_t;

    state_t           r_state;
    logic [PW-1:0]    r_p;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [15:0]      r_err;
    logic [WIDTH-1:0] r_fail_a;
    logic [WIDTH-1:0] r_fail_b;
    exp_t             r_pipe [DEPTH];

    logic             w_issue;
    logic [PW-1:0]    w_cur_p;
    exp_t             w_new;
    exp_t             w_out;
    logic             w_mismatch;
    logic [15:0]      w_err_inc;

    // Pattern issue and response check; X/Z on the response counts as a mismatch.
    always_comb begin
        w_issue    = (r_state == S_RUN) || ((r_state == S_IDLE) && start);
        w_cur_p    = (r_state == S_RUN) ? r_p : '0;
        w_new      = '0;
        w_new.vld  = w_issue;
        w_new.last = w_issue && (w_cur_p == LAST_P);
        w_new.a    = w_cur_p[PW-1:WIDTH];
        w_new.b    = w_cur_p[WIDTH-1:0];
        w_new.exp  = {1'b0, w_cur_p[PW-1:WIDTH]} + {1'b0, w_cur_p[WIDTH-1:0]};
        w_out      = r_pipe[DUT_LAT];
        w_mismatch = w_out.vld && ({carry_i, sum_i} !== w_out.exp);
        w_err_inc  = (r_err == 16'hFFFF) ? r_err : r_err + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_p      <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= '0;
            r_fail_a <= '0;
            r_fail_b <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= w_new;
            for (int i = 1; i < int'(DEPTH); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
            r_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_a <= '0;
                    r_b <= '0;
                    if (start) begin
                        r_err    <= '0;
                        r_fail_a <= '0;
                        r_fail_b <= '0;
                        r_pass   <= 1'b0;
                        r_a      <= w_new.a;
                        r_b      <= w_new.b;
                        r_p      <= w_cur_p + PW'(1);
                        r_busy   <= 1'b1;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a <= w_new.a;
                    r_b <= w_new.b;
                    r_p <= r_p + PW'(1);
                    if (w_new.last) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    r_a <= '0;
                    r_b <= '0;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // A zero count before this compare identifies the first mismatch of the run.
            if (w_mismatch) begin
                r_err <= w_err_inc;
                if (r_err == 16'd0) begin
                    r_fail_a <= w_out.a;
                    r_fail_b <= w_out.b;
                end
            end

            if (w_out.vld && w_out.last) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_pass  <= (r_err == 16'd0) && !w_mismatch;
            end
        end
    end

    assign a_o       = r_a;
    assign b_o       = r_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_a    = r_fail_a;
    assign fail_b    = r_fail_b;

endmodule
